// File: rtl/ram_fifo_ctrl.sv
// FIFO queue controller that stages an upstream stream through an external RAM,
// keeping at most one write and one read request outstanding at a time.
module ram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_write_vaild,
    input  logic             ram_write_ready,
    output logic [AW-1:0]    ram_write_address,
    output logic [WIDTH-1:0] ram_write_data,
    output logic             ram_read_vaild,
    input  logic             ram_read_ready,
    output logic [AW-1:0]    ram_read_address,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    typedef enum logic {W_IDLE, W_REQ} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_HOLD} rd_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_vaild_q, wr_vaild_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             rd_vaild_q, rd_vaild_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             wr_commit;
    logic             rd_done;

    assign in_ready = (wr_state_q == W_IDLE) && !full_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_vaild_d = wr_vaild_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (in_valid && in_ready) begin
                    wr_data_d  = in_data;
                    wr_addr_d  = wr_ptr_q[AW-1:0];
                    wr_vaild_d = 1'b1;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (ram_write_ready) begin
                    wr_commit  = 1'b1;
                    wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
                    wr_vaild_d = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // The read side only ever fetches committed entries, so it cannot overtake a pending write.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_vaild_d  = rd_vaild_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_done     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (count_q != '0) begin
                    rd_addr_d  = rd_ptr_q[AW-1:0];
                    rd_vaild_d = 1'b1;
                    rd_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (ram_read_ready) begin
                    out_data_d  = ram_read_data;
                    out_valid_d = 1'b1;
                    rd_vaild_d  = 1'b0;
                    rd_done     = 1'b1;
                    rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
                    rd_state_d  = R_HOLD;
                end
            end
            R_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rd_state_d  = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_commit && !rd_done) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_commit && rd_done) begin
            count_d = count_q - (AW+1)'(1);
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state_q  <= W_IDLE;
            rd_state_q  <= R_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            wr_vaild_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_vaild_q  <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            wr_vaild_q  <= wr_vaild_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_vaild_q  <= rd_vaild_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ram_write_vaild   = wr_vaild_q;
    assign ram_write_address = wr_addr_q;
    assign ram_write_data    = wr_data_q;
    assign ram_read_vaild    = rd_vaild_q;
    assign ram_read_address  = rd_addr_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign count             = count_q;
    assign full              = full_q;
    assign empty             = empty_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM with programmable ready latency,
// a handshake monitor, and directed vectors with hand-computed expectations.
module tb_ram_fifo_ctrl;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       ram_write_vaild;
    logic       ram_write_ready;
    logic [2:0] ram_write_address;
    logic [7:0] ram_write_data;
    logic       ram_read_vaild;
    logic       ram_read_ready;
    logic [2:0] ram_read_address;
    logic [7:0] ram_read_data;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;
    int ramLat = 0;
    int wWait = 0;
    int rWait = 0;
    logic [7:0] mem [8];

    logic [2:0] wrAddrQ [$];
    logic [7:0] wrDataQ [$];
    logic [7:0] outQ [$];

    typedef struct {
        logic [7:0] din;
        logic [2:0] expAddr;
        logic [7:0] expOut;
    } vec_t;

    vec_t vecs [3];

    ram_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .ram_write_vaild(ram_write_vaild),
        .ram_write_ready(ram_write_ready),
        .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data),
        .ram_read_vaild(ram_read_vaild),
        .ram_read_ready(ram_read_ready),
        .ram_read_address(ram_read_address),
        .ram_read_data(ram_read_data),
        .count(count),
        .full(full),
        .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: ready rises once a request has waited ramLat cycles.
    assign ram_write_ready = ram_write_vaild && (wWait >= ramLat);
    assign ram_read_ready  = ram_read_vaild && (rWait >= ramLat);
    assign ram_read_data   = mem[ram_read_address];

    always @(posedge clock) begin
        wWait <= (!ram_write_vaild || ram_write_ready) ? 0 : wWait + 1;
        rWait <= (!ram_read_vaild || ram_read_ready) ? 0 : rWait + 1;
        if (ram_write_vaild && ram_write_ready) mem[ram_write_address] <= ram_write_data;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Records completed transfers and checks that pending requests and held output stay put.
    logic       wPend = 1'b0, rPend = 1'b0, oPend = 1'b0, simPend = 1'b0;
    logic [2:0] wPendAddr, rPendAddr;
    logic [7:0] wPendData, oPendData;
    logic [3:0] simCount;

    always @(negedge clock) begin
        if (reset) begin
            if (ram_write_vaild && ram_write_ready) begin
                wrAddrQ.push_back(ram_write_address);
                wrDataQ.push_back(ram_write_data);
            end
            if (out_valid && out_ready) outQ.push_back(out_data);
            if (wPend) checkVal("wr_hold", {ram_write_vaild, ram_write_address, ram_write_data},
                                {1'b1, wPendAddr, wPendData});
            if (rPend) checkVal("rd_hold", {ram_read_vaild, ram_read_address}, {1'b1, rPendAddr});
            if (oPend) checkVal("out_hold", {out_valid, out_data}, {1'b1, oPendData});
            if (simPend) checkVal("count_sim", count, simCount);
            wPend     = ram_write_vaild && !ram_write_ready;
            wPendAddr = ram_write_address;
            wPendData = ram_write_data;
            rPend     = ram_read_vaild && !ram_read_ready;
            rPendAddr = ram_read_address;
            oPend     = out_valid && !out_ready;
            oPendData = out_data;
            simPend   = ram_write_vaild && ram_write_ready && ram_read_vaild && ram_read_ready;
            simCount  = count;
        end else begin
            wPend   = 1'b0;
            rPend   = 1'b0;
            oPend   = 1'b0;
            simPend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        int t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            checkVal("push_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input int n);
        int t = 0;
        while (outQ.size() < n && t < 600) begin
            tick();
            t++;
        end
        if (outQ.size() < n) checkVal("out_timeout", outQ.size(), n);
    endtask

    task automatic waitOutValid();
        int t = 0;
        while (!out_valid && t < 100) begin
            tick();
            t++;
        end
        if (!out_valid) checkVal("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [7:0] expOut);
        if (outQ.size() > idx) checkVal(name, outQ[idx], expOut);
    endtask

    task automatic checkWrite(input string name, input int idx, input logic [2:0] expAddr,
                              input logic [7:0] expData);
        if (wrAddrQ.size() > idx) checkVal(name, {wrAddrQ[idx], wrDataQ[idx]}, {expAddr, expData});
    endtask

    task automatic clearQueues();
        wrAddrQ.delete();
        wrDataQ.delete();
        outQ.delete();
    endtask

    task automatic checkResetValues(input string name);
        checkVal(name, {ram_write_vaild, ram_read_vaild, ram_write_address, ram_read_address,
                        ram_write_data, out_valid, out_data, count, full, empty, in_ready},
                 {1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1});
    endtask

    initial begin
        vecs[0] = '{din: 8'h01, expAddr: 3'd0, expOut: 8'h01};
        vecs[1] = '{din: 8'h02, expAddr: 3'd1, expOut: 8'h02};
        vecs[2] = '{din: 8'h03, expAddr: 3'd2, expOut: 8'h03};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        ramLat    = 0;
        repeat (2) tick();
        checkResetValues("reset_state");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkVal("idle", {in_ready, empty, count, ram_write_vaild, ram_read_vaild, out_valid},
                     {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        end

        $display("[TB] zero-wait table vectors");
        out_ready = 1'b1;
        clearQueues();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].din);
            waitOut(i + 1);
            checkWrite("vec_write", i, vecs[i].expAddr, vecs[i].din);
            checkOutput("vec_out", i, vecs[i].expOut);
        end
        repeat (3) tick();
        checkVal("vec_drained", {count, empty}, {4'd0, 1'b1});

        $display("[TB] three-cycle ram latency");
        ramLat = 3;
        clearQueues();
        applyStimulus(8'h5A);
        for (int k = 0; k < 3; k++) begin
            checkVal("lat_wait", {ram_write_vaild, ram_write_ready, ram_write_address, ram_write_data, in_ready},
                     {1'b1, 1'b0, 3'd3, 8'h5A, 1'b0});
            tick();
        end
        applyStimulus(8'hA5);
        waitOut(2);
        repeat (4) tick();
        checkVal("lat_commits", wrAddrQ.size(), 2);
        checkWrite("lat_write0", 0, 3'd3, 8'h5A);
        checkWrite("lat_write1", 1, 3'd4, 8'hA5);
        checkOutput("lat_out0", 0, 8'h5A);
        checkOutput("lat_out1", 1, 8'hA5);

        $display("[TB] fill to full with stalled output");
        ramLat    = 0;
        out_ready = 1'b0;
        clearQueues();
        for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i));
        repeat (4) tick();
        checkVal("fill7", {count, full, in_ready, out_valid, out_data},
                 {4'd7, 1'b0, 1'b1, 1'b1, 8'h10});
        applyStimulus(8'h18);
        repeat (3) tick();
        checkVal("fill8", {count, full, empty, in_ready}, {4'd8, 1'b1, 1'b0, 1'b0});
        out_ready = 1'b1;
        waitOut(9);
        for (int i = 0; i < 9; i++) checkOutput("fill_order", i, 8'h10 + 8'(i));
        repeat (3) tick();
        checkVal("fill_drained", {count, empty, full}, {4'd0, 1'b1, 1'b0});

        $display("[TB] wrap over twenty words");
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        clearQueues();
        for (int i = 0; i < 20; i++) applyStimulus(8'(i));
        waitOut(20);
        for (int i = 0; i < 20; i++) begin
            checkWrite("wrap_write", i, 3'(i % 8), 8'(i));
            checkOutput("wrap_out", i, 8'(i));
        end
        repeat (3) tick();
        checkVal("wrap_drained", {count, empty}, {4'd0, 1'b1});

        $display("[TB] reset in mid operation");
        ramLat    = 3;
        out_ready = 1'b0;
        applyStimulus(8'h33);
        waitOutValid();
        applyStimulus(8'h44);
        checkVal("pre_reset", {ram_write_vaild, out_valid, out_data}, {1'b1, 1'b1, 8'h33});
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("async_reset");
        tick();
        reset = 1'b1;
        ramLat    = 0;
        out_ready = 1'b1;
        clearQueues();
        applyStimulus(8'hAA);
        waitOut(1);
        checkWrite("post_reset_write", 0, 3'd0, 8'hAA);
        checkOutput("post_reset_out", 0, 8'hAA);
        repeat (3) tick();
        checkVal("post_reset_drained", {count, empty}, {4'd0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
